// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, ACC source select codes and the default data width.
package cpu_pkg;

  localparam int DW_DEFAULT = 8;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_NOR = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b1011;
  localparam logic [3:0] OP_SHR = 4'b1100;

  localparam logic [1:0] ACC_ALU = 2'b00;
  localparam logic [1:0] ACC_RSV = 2'b01;
  localparam logic [1:0] ACC_REG = 2'b10;
  localparam logic [1:0] ACC_IMM = 2'b11;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: A op B with a carry/borrow bit; unknown opcodes pass A through.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [3:0]    sel_alu_i,
  output logic [DW-1:0] result_o,
  output logic          carry_o
);

  logic [DW:0] sum_w;

  assign sum_w = {1'b0, a_i} + {1'b0, b_i};

  always_comb begin
    result_o = a_i;
    carry_o  = 1'b0;
    case (sel_alu_i)
      OP_ADD: begin
        result_o = sum_w[DW-1:0];
        carry_o  = sum_w[DW];
      end
      OP_SUB: begin
        result_o = a_i - b_i;
        carry_o  = (a_i < b_i);
      end
      OP_NOR: result_o = ~(a_i | b_i);
      OP_SHL: begin
        result_o = {a_i[DW-2:0], 1'b0};
        carry_o  = a_i[DW-1];
      end
      OP_SHR: begin
        result_o = {1'b0, a_i[DW-1:1]};
        carry_o  = a_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_datapath.sv
// Accumulator datapath: ACC, z/c flags and register file around cpu_alu.
// Define REGFILE_RESET_EN to clear the register file on reset; otherwise it keeps its contents.
module acc_datapath
  import cpu_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int NREG = 16
) (
  input  logic          clk,
  input  logic          CLB,
  input  logic [3:0]    operand,
  input  logic          LoadAcc,
  input  logic          LoadReg,
  input  logic [1:0]    SelACC,
  input  logic [3:0]    SelALU,
  output logic [DW-1:0] acc,
  output logic [DW-1:0] rdata,
  output logic          z,
  output logic          c
);

  logic [DW-1:0] acc_q, acc_d;
  logic          z_q, z_d;
  logic          c_q, c_d;
  logic [DW-1:0] regs_q [NREG];

  logic [DW-1:0] alu_res;
  logic          alu_carry;
  logic [DW-1:0] imm_ext;

  // No write-through: rdata shows the register as it was before this edge.
  assign rdata   = regs_q[operand];
  assign imm_ext = DW'(operand);

  cpu_alu #(.DW(DW)) u_alu (
    .a_i       (acc_q),
    .b_i       (rdata),
    .sel_alu_i (SelALU),
    .result_o  (alu_res),
    .carry_o   (alu_carry)
  );

  always_comb begin
    acc_d = acc_q;
    z_d   = z_q;
    c_d   = c_q;
    if (LoadAcc) begin
      case (SelACC)
        ACC_ALU: begin
          acc_d = alu_res;
          z_d   = (alu_res == '0);
          c_d   = alu_carry;
        end
        ACC_REG: begin
          acc_d = rdata;
          z_d   = (rdata == '0);
        end
        ACC_IMM: begin
          acc_d = imm_ext;
          z_d   = (operand == 4'd0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!CLB) begin
      acc_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      z_q   <= z_d;
      c_q   <= c_d;
    end
  end

`ifdef REGFILE_RESET_EN
  always_ff @(posedge clk) begin
    if (!CLB) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (LoadReg) begin
      regs_q[operand] <= acc_q;
    end
  end
`else
  // Reset only blocks the write; stored contents survive.
  always_ff @(posedge clk) begin
    if (CLB && LoadReg) regs_q[operand] <= acc_q;
  end
`endif

  assign acc = acc_q;
  assign z   = z_q;
  assign c   = c_q;

endmodule

// File: tb/tb_acc_datapath.sv
// Bench for acc_datapath: directed literal cases plus randomized traffic against an arithmetic model.
module tb_acc_datapath;

  localparam int DW = 8;

  logic          clk;
  logic          CLB;
  logic [3:0]    operand;
  logic          LoadAcc;
  logic          LoadReg;
  logic [1:0]    SelACC;
  logic [3:0]    SelALU;
  logic [DW-1:0] acc;
  logic [DW-1:0] rdata;
  logic          z;
  logic          c;

  int checks = 0;
  int errors = 0;

  acc_datapath #(.DW(DW), .NREG(16)) dut (
    .clk     (clk),
    .CLB     (CLB),
    .operand (operand),
    .LoadAcc (LoadAcc),
    .LoadReg (LoadReg),
    .SelACC  (SelACC),
    .SelALU  (SelALU),
    .acc     (acc),
    .rdata   (rdata),
    .z       (z),
    .c       (c)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // behavioural model: state after each edge, pushed into the expected queue
  logic [DW-1:0]   m_acc;
  logic            m_z, m_c;
  logic            m_valid = 1'b0;
  logic [DW-1:0]   m_regs [16];
  logic [15:0]     m_known = '0;
  logic [DW+1:0]   exp_q [$];

  always @(posedge clk) begin
    int a, b, res, cy;
    logic [DW-1:0] old_acc;
    if (!CLB) begin
      m_acc = '0; m_z = 1'b0; m_c = 1'b0; m_valid = 1'b1;
`ifdef REGFILE_RESET_EN
      for (int i = 0; i < 16; i++) begin
        m_regs[i] = '0;
        m_known[i] = 1'b1;
      end
`endif
    end else if (m_valid) begin
      old_acc = m_acc;
      a = int'(m_acc);
      b = int'(m_regs[operand]);
      if (LoadAcc) begin
        if (SelACC == 2'b00) begin
          case (SelALU)
            4'd1:  begin res = (a + b) % 256; cy = (a + b > 255) ? 1 : 0; end
            4'd2:  begin res = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; end
            4'd3:  begin res = 255 - (a | b); cy = 0; end
            4'd11: begin res = (a * 2) % 256; cy = (a >= 128) ? 1 : 0; end
            4'd12: begin res = a / 2; cy = a % 2; end
            default: begin res = a; cy = 0; end
          endcase
          m_acc = 8'(res); m_z = (res == 0); m_c = (cy != 0);
        end else if (SelACC == 2'b10) begin
          m_acc = 8'(b); m_z = (b == 0);
        end else if (SelACC == 2'b11) begin
          m_acc = 8'(operand); m_z = (operand == 4'd0);
        end
      end
      if (LoadReg) begin
        m_regs[operand] = old_acc;
        m_known[operand] = 1'b1;
      end
    end
    if (m_valid) exp_q.push_back({m_acc, m_z, m_c});
  end

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("model_acc_z_c", 16'({acc, z, c}), 16'(e));
    end
    if (m_known[operand]) check("model_rdata", 16'(rdata), 16'(m_regs[operand]));
  end

  // driver tasks
  task automatic do_op(input logic la, input logic lr, input logic [1:0] sa,
                       input logic [3:0] alu, input logic [3:0] op);
    @(negedge clk); #1;
    LoadAcc = la; LoadReg = lr; SelACC = sa; SelALU = alu; operand = op;
    @(posedge clk); #1;
    LoadAcc = 1'b0; LoadReg = 1'b0;
  endtask

  task automatic ldim(input logic [3:0] v);
    do_op(1'b1, 1'b0, 2'b11, 4'd0, v);
  endtask

  task automatic alu_op(input logic [3:0] op, input logic [3:0] r);
    do_op(1'b1, 1'b0, 2'b00, op, r);
  endtask

  task automatic store(input logic [3:0] r);
    do_op(1'b0, 1'b1, 2'b00, 4'd0, r);
  endtask

  // builds an 8-bit ACC value from two nibbles, using R15 as scratch
  task automatic set_acc(input logic [7:0] v);
    ldim(v[7:4]);
    repeat (4) alu_op(4'b1011, 4'd0);
    store(4'd15);
    ldim(v[3:0]);
    alu_op(4'b0001, 4'd15);
  endtask

  task automatic do_reset(input logic la, input logic lr, input logic [3:0] op);
    @(negedge clk); #1;
    CLB = 1'b0; LoadAcc = la; LoadReg = lr; SelACC = 2'b11; operand = op;
    @(posedge clk); #1;
    CLB = 1'b1; LoadAcc = 1'b0; LoadReg = 1'b0;
  endtask

  task automatic check_state(input string name, input logic [7:0] ea, input logic ez, input logic ec);
    check({name, "_acc"}, 16'(acc), 16'(ea));
    check({name, "_z"}, 16'(z), 16'(ez));
    check({name, "_c"}, 16'(c), 16'(ec));
  endtask

  initial begin
    CLB = 1'b0; LoadAcc = 1'b1; LoadReg = 1'b0; SelACC = 2'b11; SelALU = 4'd0; operand = 4'd9;
    repeat (2) @(posedge clk);
    #1;
    CLB = 1'b1; LoadAcc = 1'b0;
    check_state("reset", 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ldim(4'(i));
      store(4'(i));
    end

    // ADD with carry out, then SUB to zero
    set_acc(8'h20);
    store(4'd3);
    set_acc(8'hF0);
    alu_op(4'b0001, 4'd3);
    check_state("add", 8'h10, 1'b0, 1'b1);
    store(4'd3);
    alu_op(4'b0010, 4'd3);
    check_state("sub", 8'h00, 1'b1, 1'b0);

    // shifts and NOR
    set_acc(8'hFE);
    store(4'd0);
    set_acc(8'h81);
    alu_op(4'b1011, 4'd0);
    check_state("shl", 8'h02, 1'b0, 1'b1);
    alu_op(4'b1100, 4'd0);
    check_state("shr", 8'h01, 1'b0, 1'b0);
    alu_op(4'b0011, 4'd0);
    check_state("nor", 8'h00, 1'b1, 1'b0);

    // simultaneous register store and ACC load
    set_acc(8'h3C);
    do_op(1'b1, 1'b1, 2'b11, 4'd0, 4'd7);
    check("both_acc", 16'(acc), 16'h0007);
    check("both_r7", 16'(rdata), 16'h003C);

    // reserved select holds everything; then LDIM keeps carry
    set_acc(8'h56);
    store(4'd14);
    set_acc(8'hFF);
    alu_op(4'b0001, 4'd14);
    check_state("pre_rsv", 8'h55, 1'b0, 1'b1);
    do_op(1'b1, 1'b0, 2'b01, 4'd1, 4'd0);
    check_state("rsv", 8'h55, 1'b0, 1'b1);
    ldim(4'd5);
    check_state("ldim5", 8'h05, 1'b0, 1'b1);

    // reset overrides pending loads
    set_acc(8'hAA);
    store(4'd2);
    ldim(4'd3);
    do_reset(1'b1, 1'b1, 4'd2);
    check_state("rst2", 8'h00, 1'b0, 1'b0);
`ifdef REGFILE_RESET_EN
    check("rst_r2", 16'(rdata), 16'h0000);
`else
    check("rst_r2", 16'(rdata), 16'h00AA);
`endif

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      @(negedge clk); #1;
      CLB     = ($urandom_range(0, 39) != 0);
      LoadAcc = 1'($urandom_range(0, 1));
      LoadReg = ($urandom_range(0, 3) == 0);
      SelACC  = 2'($urandom_range(0, 3));
      SelALU  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15))
                                            : ((n % 5 == 0) ? 4'b1011 : 4'($urandom_range(1, 3)));
      operand = 4'($urandom_range(0, 15));
    end
    @(negedge clk); #1;
    CLB = 1'b1; LoadAcc = 1'b0; LoadReg = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_datapath.md
ACC_DATAPATH -- requirements
Module: acc_datapath

Interface
REQ-001 Parameter DW, default 8, meaning ACC/register/ALU data width.
REQ-002 Parameter NREG, default 16, meaning register-file depth, indexed by the 4-bit operand field.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 CLB  input  1  reset, synchronous and active-low.
REQ-005 operand  input  4  instruction low field: register index for ADD/SUB/NOR/MOVR/MOVA/JZRS/JCRS; immediate for LDIM.
REQ-006 LoadAcc  input  1  write ACC at next edge.
REQ-007 LoadReg  input  1  write ACC into R[operand] at next edge.
REQ-008 SelACC  input  2  ACC source: 00 ALU, 10 R[operand], 11 immediate, 01 reserved.
REQ-009 SelALU  input  4  ALU op, using the controller opcode values (ADD 0001, SUB 0010, NOR 0011, SHL 1011, SHR 1100).
REQ-010 acc  output  DW  current ACC value.
REQ-011 rdata  output  DW  combinational R[operand]; feeds the PC mux for register jumps.
REQ-012 z  output  1  registered zero flag to controller.
REQ-013 c  output  1  registered carry flag to controller.

Function
REQ-014 ALU is combinational on ACC (A) and R[operand] (B); result width DW plus carry bit.
REQ-015 ADD: A+B mod 2^DW, carry = bit DW of the sum.
REQ-016 SUB: A-B mod 2^DW, carry = 1 when A<B (borrow).
REQ-017 NOR: ~(A|B), carry = 0.
REQ-018 SHL: A<<1 with 0 shifted in, carry = A[DW-1]; SHR: A>>1 logical, carry = A[0]; B is ignored.
REQ-019 Any other SelALU value with SelACC=00: result = A, carry = 0.
REQ-020 LoadAcc=1, SelACC=00: ACC <= ALU result, z <= (result==0), c <= ALU carry; 1-cycle latency.
REQ-021 LoadAcc=1, SelACC=10 (MOVR): ACC <= R[operand], z <= (value==0), c unchanged.
REQ-022 LoadAcc=1, SelACC=11 (LDIM): ACC <= zero-extended operand, z <= (operand==0), c unchanged.
REQ-023 LoadAcc=1, SelACC=01: ACC, z and c hold.
REQ-024 LoadAcc=0: ACC, z and c hold regardless of SelACC/SelALU.
REQ-025 LoadReg=1: R[operand] <= ACC (pre-edge value); flags unchanged.
REQ-026 LoadAcc and LoadReg both high: both writes occur from pre-edge values (reg gets old ACC, ACC gets new value).
REQ-027 ADD/SUB/NOR with operand selecting a register written in the same cycle: ALU uses pre-edge register value.
REQ-028 rdata reflects a register write from the next cycle onward; no write-through bypass.

Reset
REQ-029 CLB=0 at a rising edge: acc=0, z=0, c=0, overriding LoadAcc/LoadReg in that cycle.
REQ-030 Reset asserted mid-instruction discards any pending write; first post-reset edge behaves per REQ-020..025.
REQ-031 Register-file contents on reset governed by REQ-032/033.

Configuration
REQ-032 With REGFILE_RESET_EN defined: all NREG registers cleared to 0 on reset.
REQ-033 Without REGFILE_RESET_EN: register file has no reset; contents retained across reset and undefined after power-up.

Structure
REQ-034 Shared package cpu_pkg: opcode constants, SelACC codes (ACC_ALU, ACC_REG, ACC_IMM), default DW.
REQ-035 One sub-module cpu_alu: purely combinational, inputs A, B, SelALU; outputs result, carry.
REQ-036 ACC, flags and register file live in acc_datapath.

Verification
REQ-037 LDIM 5 (SelACC=11, operand=5, LoadAcc) -> acc=0x05, z=0, c unchanged.
REQ-038 ACC=0xF0, R3=0x20, ADD operand=3 -> acc=0x10, c=1, z=0; then SUB with R3=0x10 -> acc=0x00, z=1, c=0.
REQ-039 ACC=0x81, SHL -> acc=0x02, c=1; SHR -> acc=0x01, c=0; NOR with R0=0xFE -> acc=0x00, z=1, c=0.
REQ-040 ACC=0x3C, LoadReg+LoadAcc with SelACC=11, operand=7 -> R7=0x3C, acc=0x07 same edge.
REQ-041 SelACC=01 with LoadAcc, ACC=0x55, z=0, c=1 -> acc/z/c unchanged.
REQ-042 R2=0xAA, CLB low one edge -> acc=0, z=0, c=0; R2=0x00 with REGFILE_RESET_EN, 0xAA without.
